serial_mag_comp_ctrl: RTL and testbench

Sequencing controller that compares two WIDTH-bit unsigned operands by time-sharing a single 4-bit `MagnitudeComparator` instance, one nibble per cycle, most-significant nibble first. It sits between a valid/ready producer of operand pairs and a valid/ready consumer of compare results. It lets wide compares reuse the existing 4-bit comparator instead of widening it.

---
 rtl/serial_mag_comp_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_serial_mag_comp_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl
//
// Compares two WIDTH-bit unsigned operands by time-sharing one 4-bit
// MagnitudeComparator, one nibble per cycle, most-significant nibble first.
// Operand pairs arrive on a valid/ready input channel; the gt/lt/eq result
// leaves on a valid/ready output channel.
//
// Optional feature macro: EARLY_EXIT_EN
//   defined   - the scan stops on the first unequal nibble (latency 1..NIBBLES)
//   undefined - every nibble is always scanned and the first unequal decision
//               is held sticky (constant latency NIBBLES, data-independent)
// Result values are the same in both builds.

// Existing 4-bit magnitude comparator that the controller time-shares.
module MagnitudeComparator (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       AgtB,
  output logic       AltB,
  output logic       AeqB
);

  assign AgtB = (A > B);
  assign AltB = (A < B);
  assign AeqB = (A == B);

endmodule

module serial_mag_comp_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

`ifdef EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  // Control state
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;

  // Captured operands
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  // Sticky first-unequal decision recorded during the scan
  logic             dec_q, dec_d;
  logic             sgt_q, sgt_d;
  logic             slt_q, slt_d;

  // Registered result presented in DONE and held through IDLE
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  // Nibble currently under comparison and the comparator's verdict on it
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic             nib_gt;
  logic             nib_lt;
  logic             nib_eq;
  logic             scan_end;

  // Route the selected nibble of each captured operand to the comparator.
  assign a_nib = a_q[int'(idx_q) * 4 +: 4];
  assign b_nib = b_q[int'(idx_q) * 4 +: 4];

  MagnitudeComparator u_cmp (
    .A    (a_nib),
    .B    (b_nib),
    .AgtB (nib_gt),
    .AltB (nib_lt),
    .AeqB (nib_eq)
  );

  // The scan finishes on the last (least-significant) nibble, or on the
  // first unequal one when early exit is built in.
  assign scan_end = (idx_q == IDX_ZERO) || (EARLY_EXIT && !nib_eq);

  // Handshake outputs are pure decodes of the state; the result is registered.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every variable gets a hold default first, so no path through the
    // case statement leaves one unassigned and no latch can be inferred.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    dec_d   = dec_q;
    sgt_d   = sgt_q;
    slt_d   = slt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_TOP;
          dec_d   = 1'b0;
          sgt_d   = 1'b0;
          slt_d   = 1'b0;
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        // Only the most-significant unequal nibble decides the ordering.
        if (!nib_eq && !dec_q) begin
          dec_d = 1'b1;
          sgt_d = nib_gt;
          slt_d = nib_lt;
        end

        if (scan_end) begin
          // Result registers change only here, on entry to DONE.
          gt_d    = sgt_d;
          lt_d    = slt_d;
          eq_d    = !dec_d;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_ZERO;
      dec_q   <= 1'b0;
      sgt_q   <= 1'b0;
      slt_q   <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      sgt_q   <= sgt_d;
      slt_q   <= slt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  // Operand capture registers.
  always_ff @(posedge clk) begin
    // NOTE: the operand registers carry no reset; they are always written on
    // accept before COMPARE reads them, so a reset adds nothing but fan-out.
    a_q <= a_d;
    b_q <= b_d;
  end

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Self-checking bench for serial_mag_comp_ctrl (WIDTH = 16).
// Expected results come from plain integer comparison of the operands and
// expected latency from locating the first unequal nibble arithmetically.
// Build with +define+EARLY_EXIT_EN to exercise the early-exit configuration.
`timescale 1ns/1ps

module tb_serial_mag_comp_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             lt;
  logic             eq;

  int checks   = 0;
  int failures = 0;

  serial_mag_comp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global safety net: the run should finish long before this.
  initial begin
    #200000;
    $display("FAIL timeout global_watchdog");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference latency: cycles from the accept edge until out_valid.
  function automatic int exp_lat(input logic [15:0] x, input logic [15:0] y);
`ifdef EARLY_EXIT_EN
    for (int p = 0; p < 4; p++) begin
      if (((int'(x) >> (12 - 4 * p)) & 15) != ((int'(y) >> (12 - 4 * p)) & 15))
        return p + 1;
    end
    return 4;
`else
    return 4;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair, scramble the inputs while busy, check the result and
  // latency, and optionally complete the output handshake.
  task automatic run_pair(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input bit do_release);
    int lat;
    bit seen;
    // Bounded wait for the controller to be ready.
    for (int w = 0; w < 8 && !in_ready; w++) tick();
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    tick();                              // accept edge E0
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = 16'($urandom);
      b        = 16'($urandom);
      tick();
      if (out_valid) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!seen) lat = -1;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat(x, y)));
    check({tag, "_gt"}, 32'(gt), 32'(x > y));
    check({tag, "_lt"}, 32'(lt), 32'(x < y));
    check({tag, "_eq"}, 32'(eq), 32'(x == y));
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    if (do_release) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_hold_res"}, 32'({gt, lt, eq}), 32'({x > y, x < y, x == y}));
    end
  endtask

  initial begin
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] flip;
    int          mode;
    bit          rose;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    // Reset held for two cycles, then released.
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'({gt, lt, eq}), 32'd0);

    // Directed operand patterns.
    run_pair("eq_1234",  16'h1234, 16'h1234, 1'b1);
    run_pair("gt_8000",  16'h8000, 16'h7FFF, 1'b1);
    run_pair("lt_1203",  16'h1203, 16'h1210, 1'b1);

    // Backpressure: result holds and input is ignored while out_ready is low.
    run_pair("bp_00f0", 16'h00F0, 16'h000F, 1'b0);
    for (int s = 0; s < 5; s++) begin
      in_valid = s[0];
      a        = 16'h0001;
      b        = 16'hFFFF;
      tick();
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_gt",       32'({gt, lt, eq}), 32'b100);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rel_valid", 32'(out_valid), 32'd0);
    check("bp_rel_ready", 32'(in_ready),  32'd1);
    run_pair("bp_next", 16'h0F00, 16'h0F00, 1'b1);

    // Reset mid-compare: rst_n sampled low at edge E2.
    in_valid = 1'b1;
    a        = 16'h1234;
    b        = 16'h1235;
    tick();                              // E0
    in_valid = 1'b0;
    tick();                              // E1
    rst_n = 1'b0;
    tick();                              // E2
    check("mid_rst_valid",  32'(out_valid), 32'd0);
    check("mid_rst_result", 32'({gt, lt, eq}), 32'd0);
    rst_n = 1'b1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    rose = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) rose = 1'b1;
    end
    check("mid_rst_no_result", 32'(rose), 32'd0);
    run_pair("post_rst", 16'h0001, 16'h0002, 1'b1);

    // Boundary operands.
    run_pair("zero_zero", 16'h0000, 16'h0000, 1'b1);
    run_pair("max_zero",  16'hFFFF, 16'h0000, 1'b1);
    run_pair("lsn_only",  16'hABC4, 16'hABC5, 1'b1);

    // Randomized pairs, biased toward equal and single-nibble differences.
    for (int i = 0; i < 24; i++) begin
      x    = 16'($urandom);
      mode = $urandom_range(0, 3);
      flip = 16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3));
      case (mode)
        0:       y = x;
        1:       y = 16'($urandom);
        default: y = x ^ flip;
      endcase
      run_pair($sformatf("rnd%0d", i), x, y, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
